// File: rtl/pixel_out_buffer.sv
// Frame capture buffer: stores one converted pixel per accepted beat and offers a registered read port.
// Build macro PIXOUT_CLAMP_EN selects saturating conversion; the default build truncates.
module pixel_out_buffer #(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 3334,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow,
  output logic [FCNT_W-1:0] frame_cnt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  typedef enum logic {ST_FILL, ST_DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PIX_W-1:0]    rd_data_q;
  logic [PIX_W-1:0]    mem_q [DEPTH];
  logic [PIX_W-1:0]    pix_d;
  logic                accept;
  logic                unused_in_data;

  assign unused_in_data = ^in_data;

`ifdef PIXOUT_CLAMP_EN
  // Signed saturation into 0..2^PIX_W-1: negative -> 0, above range -> all ones.
  always_comb begin
    pix_d = in_data[PIX_W-1:0];
    if (in_data[DATA_W-1]) begin
      pix_d = '0;
    end else if ((in_data >> PIX_W) != '0) begin
      pix_d = '1;
    end
  end
`else
  assign pix_d = in_data[PIX_W-1:0];
`endif

  assign in_ready = (state_q == ST_FILL) && !frame_start && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      state_d    = ST_FILL;
      count_d    = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (count_q == LAST_C) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              count_d     = DEPTH_C;
              frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (in_valid) begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Memory has no reset; accept already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[count_q[ADDR_W-1:0]] <= pix_d;
    end
  end

  // Read-first: a same-cycle write is not visible until the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_addr} < DEPTH_C) begin
        rd_data_q <= mem_q[rd_addr];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

  assign count     = count_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_pixel_out_buffer.sv
// Directed bench for pixel_out_buffer: a DEPTH=4 instance for the main scenarios and a
// DEPTH=5 instance so out-of-range read addresses are representable.
module tb_pixel_out_buffer;

  localparam int DATA_W = 32;
  localparam int PIX_W  = 8;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              frameStart, inValid, inReady, done, overflow, rdEn;
  logic [DATA_W-1:0] inData;
  logic [2:0]        count;
  logic [FCNT_W-1:0] frameCnt;
  logic [1:0]        rdAddr;
  logic [PIX_W-1:0]  rdData;

  logic              frameStartB, inValidB, inReadyB, doneB, overflowB, rdEnB;
  logic [DATA_W-1:0] inDataB;
  logic [3:0]        countB;
  logic [FCNT_W-1:0] frameCntB;
  logic [2:0]        rdAddrB;
  logic [PIX_W-1:0]  rdDataB;

  int checks = 0;
  int failures = 0;
  logic [PIX_W-1:0] convA, convB;

  always #5 clk = ~clk;

  pixel_out_buffer #(.DATA_W(DATA_W), .PIX_W(PIX_W), .DEPTH(4), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst), .frame_start(frameStart), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady), .count(count), .done(done), .overflow(overflow), .frame_cnt(frameCnt),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData)
  );

  pixel_out_buffer #(.DATA_W(DATA_W), .PIX_W(PIX_W), .DEPTH(5), .FCNT_W(FCNT_W)) dutB (
    .clk(clk), .rst(rst), .frame_start(frameStartB), .in_valid(inValidB), .in_data(inDataB),
    .in_ready(inReadyB), .count(countB), .done(doneB), .overflow(overflowB), .frame_cnt(frameCntB),
    .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; frameStart = 1'b0; inValid = 1'b0; inData = '0; rdEn = 1'b0; rdAddr = '0;
    frameStartB = 1'b0; inValidB = 1'b0; inDataB = '0; rdEnB = 1'b0; rdAddrB = '0;
    tick(); tick();
    checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", inReady); end
    checks++; if (count !== 3'd0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_state got count=%0d done=%b ovf=%b want 0 0 0", count, done, overflow);
    end
    checks++; if (frameCnt !== 16'd0 || rdData !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_regs got fcnt=%0d rd=%h want 0 00", frameCnt, rdData);
    end
    rst = 1'b0;
    #1;
    checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got %b want 1", inReady); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = {24'h0, vals[i]};
      #1;
      checks++; if (inReady !== 1'b1 || count !== 3'(i) || done !== 1'b0) begin
        failures++; $display("[TB] FAIL fill_beat%0d got ready=%b count=%0d done=%b want 1 %0d 0", i, inReady, count, done, i);
      end
      tick();
    end
    inValid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || count !== 3'd4 || frameCnt !== 16'd1 || inReady !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_done got done=%b count=%0d fcnt=%0d ready=%b want 1 4 1 0", done, count, frameCnt, inReady);
    end
    for (int i = 0; i < 4; i++) begin
      rdEn = 1'b1; rdAddr = 2'(i);
      tick();
      rdEn = 1'b0;
      checks++; if (rdData !== vals[i]) begin failures++; $display("[TB] FAIL fill_read%0d got %h want %h", i, rdData, vals[i]); end
    end
  endtask

  task automatic test_overflow();
    inValid = 1'b1; inData = 32'hFF;
    #1;
    checks++; if (inReady !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL ovf_pre got ready=%b ovf=%b want 0 0", inReady, overflow);
    end
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
    tick();
    inValid = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1 || done !== 1'b1 || count !== 3'd4) begin
      failures++; $display("[TB] FAIL ovf_sticky got ovf=%b done=%b count=%0d want 1 1 4", overflow, done, count);
    end
    rdEn = 1'b1; rdAddr = 2'd0;
    tick();
    rdEn = 1'b0;
    checks++; if (rdData !== 8'h11) begin failures++; $display("[TB] FAIL ovf_mem got %h want 11", rdData); end
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    #1;
    checks++; if (overflow !== 1'b0 || done !== 1'b0 || count !== 3'd0 || inReady !== 1'b1 || frameCnt !== 16'd1) begin
      failures++; $display("[TB] FAIL ovf_restart got ovf=%b done=%b count=%0d ready=%b fcnt=%0d want 0 0 0 1 1",
                           overflow, done, count, inReady, frameCnt);
    end
  endtask

  task automatic test_gaps();
    logic pat [7];
    int k;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    k = 0;
    for (int s = 0; s < 7; s++) begin
      inValid = pat[s];
      inData = pat[s] ? 32'(8'hA0 + k) : 32'hEE;
      #1;
      checks++; if (done !== 1'b0 || count !== 3'(k)) begin
        failures++; $display("[TB] FAIL gaps_step%0d got done=%b count=%0d want 0 %0d", s, done, count, k);
      end
      tick();
      if (pat[s]) k++;
    end
    inValid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || count !== 3'd4 || frameCnt !== 16'd2) begin
      failures++; $display("[TB] FAIL gaps_done got done=%b count=%0d fcnt=%0d want 1 4 2", done, count, frameCnt);
    end
    for (int i = 0; i < 4; i++) begin
      rdEn = 1'b1; rdAddr = 2'(i);
      tick();
      rdEn = 1'b0;
      checks++; if (rdData !== 8'(8'hA0 + i)) begin failures++; $display("[TB] FAIL gaps_read%0d got %h want %h", i, rdData, 8'(8'hA0 + i)); end
    end
  endtask

  task automatic test_frame_start_collision();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    inValid = 1'b1; inData = 32'h01;
    tick();
    inData = 32'h02;
    tick();
    checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL coll_count2 got %0d want 2", count); end
    frameStart = 1'b1; inData = 32'h55;
    #1;
    checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL coll_ready got %b want 0", inReady); end
    tick();
    frameStart = 1'b0; inData = 32'h66;
    #1;
    checks++; if (count !== 3'd0 || inReady !== 1'b1) begin
      failures++; $display("[TB] FAIL coll_restart got count=%0d ready=%b want 0 1", count, inReady);
    end
    tick();
    inValid = 1'b0;
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL coll_count1 got %0d want 1", count); end
    rdEn = 1'b1; rdAddr = 2'd0;
    tick();
    checks++; if (rdData !== 8'h66) begin failures++; $display("[TB] FAIL coll_addr0 got %h want 66", rdData); end
    rdAddr = 2'd1;
    tick();
    rdEn = 1'b0;
    checks++; if (rdData !== 8'h02) begin failures++; $display("[TB] FAIL coll_addr1 got %h want 02", rdData); end
  endtask

  task automatic test_conv();
`ifdef PIXOUT_CLAMP_EN
    convA = 8'hFF; convB = 8'h00;
`else
    convA = 8'h23; convB = 8'hFE;
`endif
    inValid = 1'b1; inData = 32'h0000_0123;
    tick();
    inData = 32'hFFFF_FFFE;
    rdEn = 1'b1; rdAddr = 2'd2;
    tick();
    inValid = 1'b0;
    checks++; if (rdData !== 8'hA2) begin failures++; $display("[TB] FAIL conv_read_first got %h want a2", rdData); end
    rdAddr = 2'd1;
    tick();
    checks++; if (rdData !== convA) begin failures++; $display("[TB] FAIL conv_pos got %h want %h", rdData, convA); end
    rdAddr = 2'd2;
    tick();
    rdEn = 1'b0;
    checks++; if (rdData !== convB) begin failures++; $display("[TB] FAIL conv_neg got %h want %h", rdData, convB); end
  endtask

  task automatic test_reset_midframe();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    inValid = 1'b1; inData = 32'h77;
    tick();
    inData = 32'h88;
    tick();
    inValid = 1'b0;
    checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL mid_count got %0d want 2", count); end
    rdEn = 1'b1; rdAddr = 2'd0;
    tick();
    checks++; if (rdData !== 8'h77) begin failures++; $display("[TB] FAIL mid_pre_read got %h want 77", rdData); end
    rst = 1'b1; inValid = 1'b1; inData = 32'h99; rdAddr = 2'd1;
    #1;
    checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready got %b want 0", inReady); end
    tick();
    rst = 1'b0; inValid = 1'b0; rdEn = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || done !== 1'b0 || frameCnt !== 16'd0 || rdData !== 8'h00 || overflow !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_rst got count=%0d done=%b fcnt=%0d rd=%h ovf=%b want 0 0 0 00 0",
                           count, done, frameCnt, rdData, overflow);
    end
    rdEn = 1'b1; rdAddr = 2'd1;
    tick();
    checks++; if (rdData !== 8'h88) begin failures++; $display("[TB] FAIL mid_mem_kept got %h want 88", rdData); end
    rdAddr = 2'd2;
    tick();
    rdEn = 1'b0; rdAddr = 2'd0;
    checks++; if (rdData !== convB) begin failures++; $display("[TB] FAIL mid_no_write got %h want %h", rdData, convB); end
    tick();
    checks++; if (rdData !== convB) begin failures++; $display("[TB] FAIL rd_hold got %h want %h", rdData, convB); end
  endtask

  task automatic test_out_of_range();
    inValidB = 1'b1; inDataB = 32'h5A;
    tick();
    inValidB = 1'b0;
    checks++; if (countB !== 4'd1 || doneB !== 1'b0) begin
      failures++; $display("[TB] FAIL oor_count got count=%0d done=%b want 1 0", countB, doneB);
    end
    rdEnB = 1'b1; rdAddrB = 3'd0;
    tick();
    checks++; if (rdDataB !== 8'h5A) begin failures++; $display("[TB] FAIL oor_valid_read got %h want 5a", rdDataB); end
    rdAddrB = 3'd5;
    tick();
    checks++; if (rdDataB !== 8'h00) begin failures++; $display("[TB] FAIL oor_addr5 got %h want 00", rdDataB); end
    rdAddrB = 3'd0;
    tick();
    rdAddrB = 3'd7;
    tick();
    rdEnB = 1'b0;
    checks++; if (rdDataB !== 8'h00) begin failures++; $display("[TB] FAIL oor_addr7 got %h want 00", rdDataB); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_gaps();
    test_frame_start_collision();
    test_conv();
    test_reset_midframe();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
